// File: rtl/axi4_lite_write_master.sv
// AXI4-Lite write master: turns one CPU store into AW/W/B transactions, one outstanding write at a time.
// Define AXI_WR_TIMEOUT_EN to enable the TIMEOUT_CYCLES watchdog that aborts a stuck write with wr_err.
//
// state | meaning
// IDLE  | no write in flight, req_ready high, next req_valid is captured
// XFER  | AW and/or W still presenting; each valid drops on its own handshake
// RESP  | both handshakes done, BREADY high, waiting for BVALID
module axi4_lite_write_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic [3:0]            req_strb,
    output logic                  req_ready,
    output logic                  wr_done,
    output logic                  wr_err,
    output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
    output logic                  M_AXI_AWVALID,
    input  logic                  M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
    output logic [3:0]            M_AXI_WSTRB,
    output logic                  M_AXI_WVALID,
    input  logic                  M_AXI_WREADY,
    input  logic [1:0]            M_AXI_BRESP,
    input  logic                  M_AXI_BVALID,
    output logic                  M_AXI_BREADY
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q,  awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic [3:0]            wstrb_q,   wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q,  wvalid_d;
    logic                  bready_q,  bready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q,  w_done_d;
    logic                  wr_done_q, wr_done_d;
    logic                  wr_err_q,  wr_err_d;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic unused_bits;

    assign aw_hs = awvalid_q & M_AXI_AWREADY;
    assign w_hs  = wvalid_q  & M_AXI_WREADY;
    assign b_hs  = bready_q  & M_AXI_BVALID;

`ifdef AXI_WR_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] tmr_q, tmr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign unused_bits = M_AXI_BRESP[0];
`else
    // Only BRESP[1] distinguishes error responses; the parameter is watchdog-only.
    assign unused_bits = M_AXI_BRESP[0] ^ (^TIMEOUT_CYCLES);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_done_q <= wr_done_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_done_d = 1'b0;
        wr_err_d  = 1'b0;
`ifdef AXI_WR_TIMEOUT_EN
        tmr_d     = tmr_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    awaddr_d  = req_addr;
                    wdata_d   = req_data;
                    wstrb_d   = req_strb;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = XFER;
                end
            end
            XFER: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                // Channels finish independently; leave once both are through.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    bready_d = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (b_hs) begin
                    bready_d  = 1'b0;
                    wr_done_d = 1'b1;
                    wr_err_d  = M_AXI_BRESP[1];
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef AXI_WR_TIMEOUT_EN
        // Down-counter reloaded while idle; terminal count in XFER/RESP aborts unless B lands that cycle.
        if (state_q == IDLE) begin
            tmr_d = TW'(TIMEOUT_CYCLES - 1);
        end else begin
            tmr_d = tmr_q - TW'(1);
            if ((tmr_q == '0) && !b_hs) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                wr_done_d = 1'b1;
                wr_err_d  = 1'b1;
                state_d   = IDLE;
            end
        end
`endif
    end

    assign req_ready     = (state_q == IDLE);
    assign wr_done       = wr_done_q;
    assign wr_err        = wr_err_q;
    assign M_AXI_AWADDR  = awaddr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;

endmodule

// File: tb/tb_axi4_lite_write_master.sv
// Bench for axi4_lite_write_master: configurable slave, directed plus random writes checked against timing rules.
// Build with AXI_WR_TIMEOUT_EN defined to also exercise the 16-cycle watchdog.
module tb_axi4_lite_write_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [3:0]  req_strb;
    logic        req_ready;
    logic        wr_done;
    logic        wr_err;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;

    axi4_lite_write_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_strb     (req_strb),
        .req_ready    (req_ready),
        .wr_done      (wr_done),
        .wr_err       (wr_err),
        .M_AXI_AWADDR (M_AXI_AWADDR),
        .M_AXI_AWVALID(M_AXI_AWVALID),
        .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA  (M_AXI_WDATA),
        .M_AXI_WSTRB  (M_AXI_WSTRB),
        .M_AXI_WVALID (M_AXI_WVALID),
        .M_AXI_WREADY (M_AXI_WREADY),
        .M_AXI_BRESP  (M_AXI_BRESP),
        .M_AXI_BVALID (M_AXI_BVALID),
        .M_AXI_BREADY (M_AXI_BREADY)
    );

    always #5 clk = ~clk;

    // Slave configuration; b_mode 0 = BVALID always high, 1 = after b_delay, 2 = never.
    int         cfg_aw_delay = 0;
    int         cfg_w_delay  = 0;
    int         cfg_b_delay  = 0;
    int         cfg_b_mode   = 0;
    bit         cfg_w_needs_aw = 1'b0;
    logic [1:0] cfg_resp = 2'b00;

    int aw_wait, w_wait, b_wait;
    bit aw_got, w_got;

    assign M_AXI_AWREADY = M_AXI_AWVALID && (aw_wait >= cfg_aw_delay);
    assign M_AXI_WREADY  = M_AXI_WVALID && (w_wait >= cfg_w_delay) && (!cfg_w_needs_aw || M_AXI_AWVALID);
    assign M_AXI_BVALID  = (cfg_b_mode == 0) ? 1'b1 :
                           (cfg_b_mode == 2) ? 1'b0 : (aw_got && w_got && (b_wait >= cfg_b_delay));
    assign M_AXI_BRESP   = cfg_resp;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0;
            w_wait  <= 0;
            b_wait  <= 0;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
        end else begin
            aw_wait <= (M_AXI_AWVALID && !M_AXI_AWREADY) ? aw_wait + 1 : 0;
            w_wait  <= (M_AXI_WVALID && !M_AXI_WREADY) ? w_wait + 1 : 0;
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_wait <= 0;
            end else begin
                if (M_AXI_AWVALID && M_AXI_AWREADY) aw_got <= 1'b1;
                if (M_AXI_WVALID && M_AXI_WREADY) w_got <= 1'b1;
                if (aw_got && w_got) b_wait <= b_wait + 1;
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge where wr_done is visible.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        int exp_aw, exp_w, last, exp_b;
        int aw_cyc, w_cyc, aw_n, w_n, aw_vc, w_vc, first_br, b_cyc, done_cyc;
        bit aw_bad, w_bad, done, err, rdy_at_done, br_at_done, awv_at_done;
        exp_aw = 1 + cfg_aw_delay;
        exp_w  = 1 + cfg_w_delay;
        last   = (exp_aw > exp_w) ? exp_aw : exp_w;
        exp_b  = last + 1 + ((cfg_b_mode == 1) ? cfg_b_delay : 0);
        aw_cyc = 0; w_cyc = 0; aw_n = 0; w_n = 0; aw_vc = 0; w_vc = 0;
        first_br = 0; b_cyc = 0; done_cyc = 0;
        aw_bad = 0; w_bad = 0; done = 0; err = 0; rdy_at_done = 0; br_at_done = 0; awv_at_done = 0;

        check({tag, ".req_ready"}, req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_strb  = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_strb  = 4'($urandom);
        for (int c = 1; c <= 60 && !done; c++) begin
            @(negedge clk);
            if (M_AXI_AWVALID) begin
                aw_vc++;
                if (M_AXI_AWADDR !== a) aw_bad = 1'b1;
                if (M_AXI_AWREADY) begin
                    aw_n++;
                    if (aw_cyc == 0) aw_cyc = c;
                end
            end
            if (M_AXI_WVALID) begin
                w_vc++;
                if (M_AXI_WDATA !== d || M_AXI_WSTRB !== s) w_bad = 1'b1;
                if (M_AXI_WREADY) begin
                    w_n++;
                    if (w_cyc == 0) w_cyc = c;
                end
            end
            if (M_AXI_BREADY && first_br == 0) first_br = c;
            if (M_AXI_BREADY && M_AXI_BVALID) b_cyc = c;
            if (wr_done) begin
                done        = 1'b1;
                done_cyc    = c;
                err         = wr_err;
                rdy_at_done = req_ready;
                br_at_done  = M_AXI_BREADY;
                awv_at_done = M_AXI_AWVALID | M_AXI_WVALID;
            end
        end
        check({tag, ".done_seen"}, done, 1'b1);
        check({tag, ".aw_count"}, aw_n, 1);
        check({tag, ".w_count"}, w_n, 1);
        check({tag, ".aw_cyc"}, aw_cyc, exp_aw);
        check({tag, ".w_cyc"}, w_cyc, exp_w);
        check({tag, ".awvalid_cycles"}, aw_vc, exp_aw);
        check({tag, ".wvalid_cycles"}, w_vc, exp_w);
        check({tag, ".awaddr_stable"}, aw_bad, 1'b0);
        check({tag, ".wdata_stable"}, w_bad, 1'b0);
        check({tag, ".bready_first"}, first_br, last + 1);
        check({tag, ".b_cyc"}, b_cyc, exp_b);
        check({tag, ".done_cyc"}, done_cyc, exp_b + 1);
        check({tag, ".wr_err"}, err, cfg_resp[1]);
        check({tag, ".ready_at_done"}, rdy_at_done, 1'b1);
        check({tag, ".bready_at_done"}, br_at_done, 1'b0);
        check({tag, ".valids_at_done"}, awv_at_done, 1'b0);
    endtask

    initial begin : stim
        int busy, seen_done, t_err, t_br, t_rdy, t_v;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_data  = '0;
        req_strb  = '0;
        repeat (2) @(negedge clk);
        check("rst.awvalid", M_AXI_AWVALID, 1'b0);
        check("rst.wvalid", M_AXI_WVALID, 1'b0);
        check("rst.bready", M_AXI_BREADY, 1'b0);
        check("rst.wr_done", wr_done, 1'b0);
        check("rst.wr_err", wr_err, 1'b0);
        check("rst.awaddr", M_AXI_AWADDR, 32'h0);
        check("rst.wdata", M_AXI_WDATA, 32'h0);
        check("rst.wstrb", M_AXI_WSTRB, 4'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", req_ready, 1'b1);

        run_txn(32'h1000_0010, 32'hDEAD_BEEF, 4'hF, "t1_fast");

        cfg_aw_delay = 3;
        run_txn(32'h2000_0004, 32'h1234_5678, 4'hF, "t2_aw_late");

        cfg_aw_delay = 2;
        cfg_w_needs_aw = 1'b1;
        run_txn(32'h3000_0008, 32'h0000_ABCD, 4'b0011, "t3_w_after_aw");

        cfg_aw_delay = 0;
        cfg_w_needs_aw = 1'b0;
        cfg_resp = 2'b10;
        run_txn(32'h4000_0000, 32'hCAFE_0001, 4'hC, "t4_slverr");
        cfg_resp = 2'b00;
        run_txn(32'h4000_0004, 32'hCAFE_0002, 4'h3, "t4_back2back");

        cfg_resp = 2'b01;
        run_txn(32'h4000_0008, 32'hCAFE_0003, 4'h1, "t4_exokay");

        for (int i = 0; i < 24; i++) begin
            cfg_aw_delay   = $urandom_range(0, 4);
            cfg_w_delay    = $urandom_range(0, 4);
            cfg_w_needs_aw = 1'($urandom_range(0, 1));
            if (cfg_w_needs_aw && cfg_w_delay > cfg_aw_delay) cfg_w_delay = cfg_aw_delay;
            cfg_b_mode  = $urandom_range(0, 1);
            cfg_b_delay = $urandom_range(0, 3);
            cfg_resp    = 2'($urandom_range(0, 3));
            run_txn($urandom, $urandom, 4'($urandom), $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        // Reset while waiting in RESP.
        cfg_aw_delay = 0; cfg_w_delay = 0; cfg_w_needs_aw = 1'b0; cfg_b_mode = 2; cfg_resp = 2'b00;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h5000_0000;
        req_data  = 32'h5555_AAAA;
        req_strb  = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 20 && !M_AXI_BREADY; c++) @(negedge clk);
        check("rstmid.in_resp", M_AXI_BREADY, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rstmid.awvalid", M_AXI_AWVALID, 1'b0);
        check("rstmid.wvalid", M_AXI_WVALID, 1'b0);
        check("rstmid.bready", M_AXI_BREADY, 1'b0);
        check("rstmid.wr_done", wr_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (wr_done) seen_done = 1;
        end
        check("rstmid.no_done", seen_done, 0);
        check("rstmid.req_ready", req_ready, 1'b1);

`ifdef AXI_WR_TIMEOUT_EN
        busy = 0; seen_done = 0; t_err = 0; t_br = 1; t_rdy = 0; t_v = 1;
        req_valid = 1'b1;
        req_addr  = 32'h6000_0000;
        req_data  = 32'h6666_6666;
        req_strb  = 4'hF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 0; c < 100 && seen_done == 0; c++) begin
            @(negedge clk);
            if (!req_ready) busy++;
            if (wr_done) begin
                seen_done = 1;
                t_err = int'(wr_err);
                t_br  = int'(M_AXI_BREADY);
                t_rdy = int'(req_ready);
                t_v   = int'(M_AXI_AWVALID | M_AXI_WVALID);
            end
        end
        check("tmo.done_seen", seen_done, 1);
        check("tmo.busy_cycles", busy, 16);
        check("tmo.wr_err", t_err, 1);
        check("tmo.bready", t_br, 0);
        check("tmo.valids", t_v, 0);
        check("tmo.idle", t_rdy, 1);
`else
        busy = 0; t_err = 0; t_br = 0; t_rdy = 0; t_v = 0;
`endif

        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (wr_done) seen_done = 1;
        end
        check("tail.no_spurious_done", seen_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi4_lite_write_master.md
Name: axi4_lite_write_master

Overview:
- AXI4-Lite write-channel master that converts a single-beat CPU store request into AW/W/B transactions.
- Sits between the core's load/store unit and the interconnect or write slave.
- Drives one outstanding write at a time. Presents the AW and W channels independently and waits for the B response.
- Reports completion and error back to the core, which stalls on req_ready.

Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (strobe is fixed at 4 bits)
- TIMEOUT_CYCLES, 256, watchdog limit; used only with AXI_WR_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  core requests a store
- req_addr  in  ADDR_WIDTH  store address
- req_data  in  DATA_WIDTH  store data
- req_strb  in  4  byte enables
- req_ready  out  1  master can accept a request (core stalls when 0)
- wr_done  out  1  one-cycle pulse: write completed
- wr_err  out  1  valid with wr_done: BRESP[1] set, or timeout
- M_AXI_AWADDR  out  ADDR_WIDTH  write address
- M_AXI_AWVALID  out  1  address valid
- M_AXI_AWREADY  in  1  slave accepts address
- M_AXI_WDATA  out  DATA_WIDTH  write data
- M_AXI_WSTRB  out  4  byte strobes
- M_AXI_WVALID  out  1  data valid
- M_AXI_WREADY  in  1  slave accepts data
- M_AXI_BRESP  in  2  write response
- M_AXI_BVALID  in  1  response valid
- M_AXI_BREADY  out  1  master ready for response

Behaviour:
- Reset (async, rst=1): state IDLE; all AXI valids and BREADY 0; wr_done 0; wr_err 0; AWADDR, WDATA and WSTRB registers 0; aw_done and w_done flags 0; req_ready 1 once rst deasserts.
- All AXI outputs, wr_done and wr_err are registered. req_ready is combinational: 1 only in IDLE.
- States: IDLE, XFER, RESP.
- IDLE, on req_valid:
  - capture addr, data and strb into the output registers;
  - set AWVALID=1 and WVALID=1 on the next edge;
  - clear aw_done and w_done;
  - go to XFER.
  - With req_valid=0, stay in IDLE.
- XFER:
  - AWVALID holds until AWVALID&AWREADY sampled high, then drops to 0 and aw_done is set.
  - WVALID behaves the same way with WREADY and sets w_done.
  - The two handshakes may occur in the same cycle or in either order. A slave that waits for AWVALID before raising WREADY must not deadlock.
  - Address and data registers are stable while their valid is high.
  - Once both handshakes are complete (including the same cycle as the last one), go to RESP with BREADY=1.
- RESP:
  - BREADY=1.
  - On BVALID: BREADY drops to 0, wr_done=1 for exactly one cycle, wr_err=BRESP[1] (SLVERR/DECERR) in the same cycle, go to IDLE.
  - OKAY and EXOKAY both report wr_err=0.
- Minimum latency, slave always ready: request accepted at edge N, AW/W handshake at N+1, B accepted at N+2 if BVALID is already high, wr_done high in cycle N+3.
- Back-to-back: req_ready returns to 1 in the same cycle wr_done is high, so the next request can be accepted in that cycle.
- Values on req_* outside IDLE are ignored.
- Reset mid-transaction: everything returns to reset values immediately; the in-flight write is dropped and no wr_done is issued.
- BVALID arriving before AW/W complete is ignored (BREADY is 0).

Optional Feature:
- Macro: AXI_WR_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on entry to XFER and increments every cycle in XFER or RESP.
  - When it reaches TIMEOUT_CYCLES-1 without the B handshake: force AWVALID, WVALID and BREADY to 0, pulse wr_done=1 with wr_err=1, return to IDLE.
  - The B handshake in the expiry cycle takes priority: normal completion, no timeout.
- Not defined: no counter logic; the master waits indefinitely in XFER or RESP.

Test Plan:
- Slave with all readys tied high and BVALID high, BRESP=00. Request addr=0x1000_0010, data=0xDEADBEEF, strb=4'hF. Required: AWADDR/WDATA/WSTRB match; one wr_done pulse in cycle N+3; wr_err=0.
- AWREADY delayed 3 cycles, WREADY immediate. Required: WVALID drops after 1 cycle; AWVALID held 4 cycles with AWADDR stable; BREADY rises only after both handshakes.
- Slave that raises WREADY only while AWVALID is high (as the team's write slave does), strb=4'b0011, data=0x0000_ABCD. Required: completes without deadlock; WSTRB=4'b0011.
- BRESP=2'b10 on completion. Required: wr_done=1 and wr_err=1 in the same cycle; the next request is accepted in the same cycle as wr_done.
- rst pulsed while in RESP with BVALID=0. Required: all valids and BREADY go 0 asynchronously; no wr_done; req_ready=1 after rst deasserts.
- With AXI_WR_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, BVALID never asserted. Required: exactly 16 cycles in XFER+RESP, then wr_done=1 and wr_err=1, BREADY=0, state IDLE.
